if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Holds the PC and drives the instruction-memory address; imem returns the instruction combinationally in the same cycle.
- Latches instruction, PC and valid into IF/ID.
- Obeys the load-use stall controls (PCwrite, IF_IDwrite) from the hazard detection unit.
- Exports the rs1/rs2 fields that the hazard unit compares, and flushes on a taken branch from EX.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
PCwrite  in  1  1 = PC may advance; 0 = hold PC (hazard stall)
IF_IDwrite  in  1  1 = IF/ID may load; 0 = hold IF/ID (hazard stall)
branch_taken  in  1  taken branch/jump resolved in EX; flush request
branch_target  in  XLEN  redirect address, valid when branch_taken=1
imem_addr  out  XLEN  instruction-memory address (= PC)
imem_rdata  in  32  instruction word for imem_addr, same cycle
IF_IDpc  out  XLEN  PC of instruction held in IF/ID
IF_IDinstr  out  32  instruction held in IF/ID
IF_IDvalid  out  1  1 = IF/ID holds a real instruction; 0 = bubble
IF_IDrs1  out  5  IF_IDinstr[19:15]
IF_IDrs2  out  5  IF_IDinstr[24:20]
stall_count  out  32  stall cycles (only with IF_PERF_CNT_EN)
flush_count  out  32  flush events (only with IF_PERF_CNT_EN)

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high; it applies immediately, with no clock required.
- Values while reset is asserted:
  - PC=RESET_PC
  - IF_IDinstr=NOP_INSTR
  - IF_IDpc=0
  - IF_IDvalid=0
  - counters=0
- First fetch: the first valid instruction appears in IF/ID one rising edge after reset deasserts.
- imem_addr = PC, combinational. The low 2 bits of the PC are always 0.
- PC update, per rising edge, in priority order:
  1. branch_taken=1: PC <= {branch_target[XLEN-1:2],2'b00}. This ignores PCwrite, because the redirect beats the stall.
  2. PCwrite=1: PC <= PC+4. Arithmetic is modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0.
  3. Otherwise PC holds.
- IF/ID update, per rising edge, in priority order:
  1. branch_taken=1: IF_IDinstr <= NOP_INSTR, IF_IDvalid <= 0, IF_IDpc <= 0. The flush overrides IF_IDwrite=0.
  2. IF_IDwrite=1: IF_IDinstr <= imem_rdata, IF_IDpc <= PC, IF_IDvalid <= 1.
  3. Otherwise all IF/ID fields hold.
- Flush depth: only IF/ID is flushed here. The ID/EX flush belongs to the ID/EX register.
- Branch and stall in the same cycle: the branch wins for both PC and IF/ID. The next cycle fetches branch_target.
- PCwrite and IF_IDwrite are treated independently. The mismatched case (PCwrite=1, IF_IDwrite=0) is legal; the skipped instruction is lost. The hazard unit never drives it; verification flags it with an assertion warning only.
- IF_IDrs1/IF_IDrs2 are pure field slices. They are valid even when IF_IDvalid=0; a NOP gives 0/0.
- Reset mid-stall or mid-branch: reset dominates. The state returns to the reset values asynchronously.
- Latency:
  - imem_addr to IF/ID output: 1 cycle.
  - branch_taken to first fetch at the target: the target is on imem_addr in the cycle after the edge.

Optional Feature:
IF_PERF_CNT_EN
- Defined:
  - stall_count increments each edge with PCwrite=0 && branch_taken=0.
  - flush_count increments each edge with branch_taken=1.
  - Both are 32-bit and wrap at 2^32 to 0; both reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built. Functional behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN
  - NOP_INSTR
  - instruction field positions (RS1_LSB=15, RS2_LSB=20, RD_LSB=7)
  - reset-PC default
- One natural sub-module: if_id_reg, the IF/ID register with load/flush/hold priority. The PC register and counters stay inline in if_stage.

Test Plan:
- Reset: assert reset mid-run -> immediately PC=0, IF_IDinstr=0x00000013, IF_IDvalid=0. Release reset, imem_rdata=0x00500093 -> after 1 edge IF_IDinstr=0x00500093, IF_IDpc=0, IF_IDvalid=1, PC=4.
- Straight-line: 4 edges with PCwrite=IF_IDwrite=1 -> PC goes 4,8,12,16 and IF_IDpc lags by one.
- Load-use stall: at PC=8, hold PCwrite=IF_IDwrite=0 for 1 cycle -> PC stays 8, IF/ID unchanged; releasing the stall resumes at 12. With the feature: stall_count=1.
- Branch flush: branch_taken=1, branch_target=0x40 -> next edge PC=0x40, IF_IDinstr=0x13, IF_IDvalid=0; the following edge loads the 0x40 instruction.
- Branch plus stall in the same cycle: branch_taken=1, PCwrite=0, IF_IDwrite=0, target=0x103 -> PC=0x100, IF/ID flushed, flush_count +1, stall_count unchanged.
- Wrap: PC=0xFFFF_FFFC with PCwrite=1 -> next PC=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, bubble encoding, instruction field positions
// and the IF-stage update selectors.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_STEP,
        PC_REDIRECT
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_FLUSH
    } ifid_op_e;

    // A taken branch beats a hazard stall for both the PC and the IF/ID register.
    function automatic pc_sel_e pc_select(input logic branch, input logic pc_write);
        if (branch)
            return PC_REDIRECT;
        else if (pc_write)
            return PC_STEP;
        else
            return PC_HOLD;
    endfunction

    function automatic ifid_op_e ifid_select(input logic branch, input logic ifid_write);
        if (branch)
            return IFID_FLUSH;
        else if (ifid_write)
            return IFID_LOAD;
        else
            return IFID_HOLD;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  ifid_op_e        op,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else begin
            case (op)
                IFID_FLUSH: begin
                    pc    <= '0;
                    instr <= NOP_INSTR;
                    valid <= 1'b0;
                end
                IFID_LOAD: begin
                    pc    <= pc_in;
                    instr <= instr_in;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem addressing and the IF/ID register.
// Optional stall/flush counters are built only when IF_PERF_CNT_EN is defined.
module if_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC_DEFAULT),
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCwrite,
    input  logic                 IF_IDwrite,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      branch_target,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [XLEN-1:0]      IF_IDpc,
    output logic [31:0]          IF_IDinstr,
    output logic                 IF_IDvalid,
    output logic [REG_IDX_W-1:0] IF_IDrs1,
    output logic [REG_IDX_W-1:0] IF_IDrs2,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    pc_sel_e         pc_sel;
    ifid_op_e        ifid_op;

    always_comb begin
        pc_sel  = pc_select(branch_taken, PCwrite);
        ifid_op = ifid_select(branch_taken, IF_IDwrite);
        // NOTE: defaults first so no path through this block leaves pc_d unassigned (no latch).
        pc_d    = pc_q;
        case (pc_sel)
            PC_REDIRECT: pc_d = branch_target & ~XLEN'(3);
            PC_STEP:     pc_d = pc_q + XLEN'(4);
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .op       (ifid_op),
        .pc_in    (pc_q),
        .instr_in (imem_rdata),
        .pc       (IF_IDpc),
        .instr    (IF_IDinstr),
        .valid    (IF_IDvalid)
    );

    // Raw field slices for the hazard unit; a bubble reads as x0/x0.
    assign IF_IDrs1 = IF_IDinstr[RS1_LSB +: REG_IDX_W];
    assign IF_IDrs2 = IF_IDinstr[RS2_LSB +: REG_IDX_W];

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!PCwrite && !branch_taken)
                stall_count <= stall_count + 32'd1;
            if (branch_taken)
                flush_count <= flush_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table plus IF/ID scoreboard, then
// hand-written mid-run reset and PC wrap sequences.
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCwrite;
    logic        IF_IDwrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IF_IDpc;
    logic [31:0] IF_IDinstr;
    logic        IF_IDvalid;
    logic [4:0]  IF_IDrs1;
    logic [4:0]  IF_IDrs2;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    ifid_t       sb[$];
    ifid_t       last;
    logic [31:0] m_pc;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_for(input logic [31:0] addr);
        if (addr == 32'h0)
            return 32'h0050_0093;
        return {addr[29:0], 2'b11} ^ 32'h0F0F_0000;
    endfunction

    assign imem_rdata = instr_for(imem_addr);

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .PCwrite       (PCwrite),
        .IF_IDwrite    (IF_IDwrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .IF_IDpc       (IF_IDpc),
        .IF_IDinstr    (IF_IDinstr),
        .IF_IDvalid    (IF_IDvalid),
        .IF_IDrs1      (IF_IDrs1),
        .IF_IDrs2      (IF_IDrs2),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    // The hazard unit never advances the PC while freezing IF/ID outside a flush.
    always @(posedge clk) begin
        if (!reset)
            assert (!(PCwrite && !IF_IDwrite && !branch_taken))
            else $warning("PCwrite=1 with IF_IDwrite=0 drops an instruction");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_stall = 32'h0;
        m_flush = 32'h0;
        last    = '{pc: 32'h0, instr: 32'h0000_0013, valid: 1'b0};
        sb.delete();
    endtask

    task automatic check_counters(input string tag);
`ifdef IF_PERF_CNT_EN
        check({tag, " stall_count"}, stall_count, m_stall);
        check({tag, " flush_count"}, flush_count, m_flush);
`else
        check({tag, " stall_count"}, stall_count, 32'h0);
        check({tag, " flush_count"}, flush_count, 32'h0);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pc"},         imem_addr,          32'h0);
        check({tag, " IF_IDinstr"}, IF_IDinstr,         32'h0000_0013);
        check({tag, " IF_IDvalid"}, 32'(IF_IDvalid),    32'h0);
        check({tag, " IF_IDpc"},    IF_IDpc,            32'h0);
        check({tag, " rs1/rs2"},    {IF_IDrs1, IF_IDrs2}, 32'h0);
        check_counters(tag);
    endtask

    // Called just after a falling edge: drive, model, clock once, compare, return at next falling edge.
    task automatic step(input vec_t v, input string tag);
        ifid_t e;
        ifid_t got;
        PCwrite       = v.pcw;
        IF_IDwrite    = v.ifw;
        branch_taken  = v.br;
        branch_target = v.tgt;

        if (v.br)
            e = '{pc: 32'h0, instr: 32'h0000_0013, valid: 1'b0};
        else if (v.ifw)
            e = '{pc: m_pc, instr: instr_for(m_pc), valid: 1'b1};
        else
            e = last;
        if (!v.pcw && !v.br) m_stall = m_stall + 32'd1;
        if (v.br)            m_flush = m_flush + 32'd1;
        if (v.br)
            m_pc = {v.tgt[31:2], 2'b00};
        else if (v.pcw)
            m_pc = m_pc + 32'd4;
        last = e;
        sb.push_back(e);

        @(posedge clk);
        #1;
        check({tag, " pc"},         imem_addr,       v.exp_pc);
        check({tag, " IF_IDvalid"}, 32'(IF_IDvalid), 32'(v.exp_valid));
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: got=empty want=entry", tag);
        end else begin
            got = sb.pop_front();
            check({tag, " IF_IDpc"},    IF_IDpc,          got.pc);
            check({tag, " IF_IDinstr"}, IF_IDinstr,       got.instr);
            check({tag, " IF_IDrs1"},   32'(IF_IDrs1),    32'(got.instr[19:15]));
            check({tag, " IF_IDrs2"},   32'(IF_IDrs2),    32'(got.instr[24:20]));
        end
        check_counters(tag);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vec_t vecs[12];

        //               pcw   ifw   br    target        exp_pc        exp_valid
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0004, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0008, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_000C, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0010, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0014, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h40,       32'h0000_0040, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0044, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h103,      32'h0000_0100, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0104, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0104, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h200,      32'h0000_0200, 1'b0};

        reset         = 1'b1;
        PCwrite       = 1'b0;
        IF_IDwrite    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        model_reset();
        #1;
        check_reset_values("por");

        @(negedge clk);
        reset = 1'b0;
        foreach (vecs[i])
            step(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a branch, with no clock edge in between.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("midrun");
        @(negedge clk);
        reset = 1'b0;
        step('{1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0004, 1'b1}, "after_reset");

        // Redirect to the top of the address space, then step across the wrap.
        step('{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0}, "to_top");
        step('{1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_0000, 1'b1}, "wrap");
        step('{1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_0004, 1'b1}, "post_wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
